// File: rtl/mem_req_adapter.sv
// Valid/ready front-end for one port of a fixed-latency memory. Read data is
// captured into a credit-protected response FIFO so the consumer may stall freely.
module mem_req_adapter #(
  parameter int WIDTH      = 16,
  parameter int LENGTH     = 32,
  parameter int DELAY      = 1,
  parameter int RESP_DEPTH = 2,
  localparam int AW        = $clog2(LENGTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reqValid_i,
  output logic             reqReady_o,
  input  logic             reqWr_i,
  input  logic [AW-1:0]    reqAddr_i,
  input  logic [WIDTH-1:0] reqData_i,
  output logic             rspValid_o,
  input  logic             rspReady_i,
  output logic [WIDTH-1:0] rspData_o,
  output logic             memEn_o,
  output logic             memWr_o,
  output logic [AW-1:0]    memAddr_o,
  output logic [WIDTH-1:0] memDataIn_o,
  input  logic [WIDTH-1:0] memDataOut_i
);

  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int PNW = $clog2(DELAY + RESP_DEPTH + 1);

  logic [DELAY-1:0] inFlight_q, inFlight_d;
  logic [WIDTH-1:0] fifo_q [RESP_DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PNW-1:0]   pending;
  logic             reqAccept, rdAccept, push, pop;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every read in flight or buffered holds a FIFO slot; only registered state
  // feeds the credit check, so neither handshake input reaches reqReady_o.
  always_comb begin
    pending = PNW'(count_q);
    for (int i = 0; i < DELAY; i++) begin
      pending = pending + PNW'(inFlight_q[i]);
    end
  end

  assign reqReady_o  = rst_ni && (pending < PNW'(RESP_DEPTH));
  assign reqAccept   = reqValid_i && reqReady_o;
  assign rdAccept    = reqAccept && !reqWr_i;

  assign memEn_o     = reqAccept;
  assign memWr_o     = reqAccept && reqWr_i;
  assign memAddr_o   = reqAddr_i;
  assign memDataIn_o = reqData_i;

  assign push        = inFlight_q[DELAY-1];
  assign rspValid_o  = rst_ni && (count_q != '0);
  assign pop         = rspValid_o && rspReady_i;
  assign rspData_o   = fifo_q[rdPtr_q];

  always_comb begin
    inFlight_d    = '0;
    inFlight_d[0] = rdAccept;
    for (int i = 1; i < DELAY; i++) begin
      inFlight_d[i] = inFlight_q[i-1];
    end
    wrPtr_d = push ? ptrInc(wrPtr_q) : wrPtr_q;
    rdPtr_d = pop  ? ptrInc(rdPtr_q) : rdPtr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inFlight_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      inFlight_q <= inFlight_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      fifo_q[wrPtr_q] <= memDataOut_i;
    end
  end

  noOverflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (count_q != CW'(RESP_DEPTH)));

endmodule
